// File: rtl/result_uart_sender_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_uart_sender_pkg : FSM state encoding and header-byte format
// Rev 1.0
// ---------------------------------------------------------------------------
package result_uart_sender_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_HDR  = 4'd1,
    S_RD   = 4'd2,
    S_RDW  = 4'd3,
    S_SEND = 4'd4,
    S_ACK  = 4'd5,
    S_FIN  = 4'd6,
    S_DONE = 4'd7
  } state_t;

  localparam int c_HDR_PAD_W = 4;

  function automatic logic [7:0] hdr_byte(input logic [3:0] n);
    return {{c_HDR_PAD_W{1'b0}}, n};
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_uart_sender_sync_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_bit : multi-flop single-bit synchroniser, clears to 0 on reset
// Rev 1.0
// ---------------------------------------------------------------------------
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/result_uart_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_uart_sender : streams the N x N result memory, MSB byte first, to uart_tx
// Rev 1.0
// ---------------------------------------------------------------------------
module result_uart_sender
  import result_uart_sender_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 4,
  parameter int MAX_N       = 4,
  parameter int SEND_HEADER = 1,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_req,
  input  logic [3:0]        matrix_size,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_rd_en,
  input  logic [DATA_W-1:0] res_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              sending,
  output logic              done,
  output logic              err
);

  localparam int c_BYTES = DATA_W / 8;
  localparam int c_BCW   = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
  localparam int c_IW    = ADDR_W + 1;
  localparam int c_TW    = $clog2(ACK_TIMEOUT + 1);

  state_t            r_state;
  logic              r_hdr;
  logic [3:0]        r_n;
  logic [c_IW-1:0]   r_idx;
  logic [c_IW-1:0]   r_nn;
  logic [c_BCW-1:0]  r_bcnt;
  logic [DATA_W-1:0] r_shift;
  logic [c_TW-1:0]   r_tmo;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_en;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic              r_sending;
  logic              r_done;
  logic              r_err;

  logic              w_busy_s;
  logic [3:0]        w_n;
  logic [c_IW-1:0]   w_nn;
  logic [c_IW-1:0]   w_idx_nxt;
  logic [DATA_W-1:0] w_shift_nxt;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_busy_sync (
    .clk (clk),
    .rst (rst),
    .d   (tx_busy),
    .q   (w_busy_s)
  );

  assign w_n         = (matrix_size > 4'(MAX_N)) ? 4'(MAX_N) : matrix_size;
  assign w_nn        = c_IW'(w_n) * c_IW'(w_n);
  assign w_idx_nxt   = r_idx + c_IW'(1);
  assign w_shift_nxt = r_shift << 8;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hdr      <= 1'b0;
      r_n        <= '0;
      r_idx      <= '0;
      r_nn       <= '0;
      r_bcnt     <= '0;
      r_shift    <= '0;
      r_tmo      <= '0;
      r_addr     <= '0;
      r_rd_en    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_sending  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (send_req) begin
            r_n   <= w_n;
            r_nn  <= w_nn;
            r_idx <= '0;
            if (SEND_HEADER != 0) begin
              r_sending <= 1'b1;
              r_state   <= S_HDR;
            end else if (w_n == 4'd0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_sending <= 1'b1;
              r_addr    <= '0;
              r_rd_en   <= 1'b1;
              r_state   <= S_RD;
            end
          end
        end
        S_HDR: begin
          r_tx_data  <= hdr_byte(r_n);
          r_hdr      <= 1'b1;
          r_tx_start <= 1'b1;
          r_tmo      <= '0;
          r_state    <= S_SEND;
        end
        S_RD: begin
          r_state <= S_RDW;
        end
        S_RDW: begin
          r_shift    <= res_data;
          r_tx_data  <= res_data[DATA_W-1 -: 8];
          r_bcnt     <= c_BCW'(c_BYTES - 1);
          r_tx_start <= 1'b1;
          r_tmo      <= '0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_busy_s) begin
            r_tx_start <= 1'b0;
            r_state    <= S_ACK;
          end else if (r_tmo == c_TW'(ACK_TIMEOUT - 1)) begin
            r_tx_start <= 1'b0;
            r_sending  <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + c_TW'(1);
          end
        end
        S_ACK: begin
          if (!w_busy_s) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          if (r_hdr) begin
            r_hdr <= 1'b0;
            if (r_n == 4'd0) begin
              r_done    <= 1'b1;
              r_sending <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_addr  <= '0;
              r_rd_en <= 1'b1;
              r_state <= S_RD;
            end
          end else if (r_bcnt != '0) begin
            // next lower byte of the same word; tx_start rises with the new data
            r_shift    <= w_shift_nxt;
            r_tx_data  <= w_shift_nxt[DATA_W-1 -: 8];
            r_bcnt     <= r_bcnt - c_BCW'(1);
            r_tx_start <= 1'b1;
            r_tmo      <= '0;
            r_state    <= S_SEND;
          end else if (w_idx_nxt < r_nn) begin
            r_idx   <= w_idx_nxt;
            r_addr  <= ADDR_W'(w_idx_nxt);
            r_rd_en <= 1'b1;
            r_state <= S_RD;
          end else begin
            r_done    <= 1'b1;
            r_sending <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign res_addr  = r_addr;
  assign res_rd_en = r_rd_en;
  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign sending   = r_sending;
  assign done      = r_done;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_sender.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_result_uart_sender : randomised self-checking bench with a uart_tx busy model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_result_uart_sender;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int MAX_N  = 4;
  localparam int SYNC   = 2;
  localparam int TMO    = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, send_req, tx_busy;
  logic [3:0]        matrix_size;
  logic [ADDR_W-1:0] res_addr;
  logic              res_rd_en, tx_start, sending, done, err;
  logic [DATA_W-1:0] res_data;
  logic [7:0]        tx_data;

  logic              send_req0, tx_busy0, res_rd_en0, tx_start0, sending0, done0, err0;
  logic [3:0]        matrix_size0;
  logic [ADDR_W-1:0] res_addr0;
  logic [DATA_W-1:0] res_data0;
  logic [7:0]        tx_data0;

  result_uart_sender #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_N(MAX_N), .SEND_HEADER(1),
    .SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .send_req(send_req), .matrix_size(matrix_size),
    .res_addr(res_addr), .res_rd_en(res_rd_en), .res_data(res_data),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .sending(sending), .done(done), .err(err)
  );

  result_uart_sender #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_N(MAX_N), .SEND_HEADER(0),
    .SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO)
  ) dut0 (
    .clk(clk), .rst(rst), .send_req(send_req0), .matrix_size(matrix_size0),
    .res_addr(res_addr0), .res_rd_en(res_rd_en0), .res_data(res_data0),
    .tx_data(tx_data0), .tx_start(tx_start0), .tx_busy(tx_busy0),
    .sending(sending0), .done(done0), .err(err0)
  );

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [16];
  always @(posedge clk) if (res_rd_en) res_data <= mem[res_addr];

  // uart_tx model: 0 = quick busy pulse, 1 = busy never rises, 2 = slow baud-like busy
  int mode = 0;
  logic [7:0] got_q [$];
  initial begin
    int phase, dly, hold;
    tx_busy = 1'b0;
    phase = 0; dly = 0; hold = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        tx_busy = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (tx_start && mode != 1) begin
               got_q.push_back(tx_data);
               dly = (mode == 2) ? $urandom_range(0, 8) : $urandom_range(0, 2);
               phase = 1;
             end
          1: if (dly == 0) begin
               tx_busy = 1'b1;
               hold = (mode == 2) ? $urandom_range(16, 48) : $urandom_range(0, 3);
               phase = 2;
             end else dly--;
          2: if (hold == 0) begin
               tx_busy = 1'b0;
               phase = 3;
             end else hold--;
          default: if (!tx_start) phase = 0;
        endcase
      end
    end
  end

  // observation at the falling edge; bhist mirrors what the DUT's synchroniser holds
  logic [ADDR_W-1:0] addr_q [$];
  int done_cnt = 0, err_cnt = 0, start_hi = 0, viol_cnt = 0;
  initial begin
    logic [SYNC-1:0] bhist;
    logic prev_start, prev_bs, prev_rst;
    logic [7:0] prev_data;
    bhist = '0; prev_start = 1'b0; prev_bs = 1'b0; prev_rst = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (res_rd_en) addr_q.push_back(res_addr);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (tx_start) start_hi++;
      if (rst && prev_rst && (tx_data !== prev_data) && (prev_start || prev_bs)) viol_cnt++;
      prev_data  = tx_data;
      prev_start = tx_start;
      prev_bs    = bhist[SYNC-1];
      prev_rst   = rst;
      bhist      = {bhist[SYNC-2:0], tx_busy};
    end
  end

  logic [7:0]        exp_q [$];
  logic [ADDR_W-1:0] exp_addr [$];

  // reference stream: optional header N, then words row-major, MSB byte first
  task automatic build_exp(input int ms);
    int n;
    n = (ms > MAX_N) ? MAX_N : ms;
    exp_q.delete();
    exp_addr.delete();
    exp_q.push_back(8'(n));
    for (int i = 0; i < n * n; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      for (int b = DATA_W / 8 - 1; b >= 0; b--) exp_q.push_back(mem[i][8*b +: 8]);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    addr_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    start_hi = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = DATA_W'($urandom);
  endtask

  task automatic do_transfer(input int ms, input int budget, output bit ok);
    clear_obs();
    @(posedge clk); #1;
    send_req = 1'b1;
    matrix_size = ms[3:0];
    @(posedge clk); #1;
    send_req = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done_cnt > 0 || err_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    checks++; if (sending !== 1'b0) begin errors++; $display("FAIL reset_sending got %b exp 0", sending); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b exp 00", done, err); end
    checks++; if (res_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", res_rd_en); end
    checks++; if (tx_data !== 8'h00 || res_addr !== '0) begin errors++; $display("FAIL reset_data_addr got %h/%h exp 00/0", tx_data, res_addr); end
    checks++; if (tx_start0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_dut0 got %b%b exp 00", tx_start0, done0); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_spec_example();
    logic [7:0] ref_b [9];
    bit ok;
    ref_b = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFF};
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0001; mem[3] = 16'hFFFF;
    mode = 0;
    do_transfer(2, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL example_timeout got no done exp done"); end
    checks++;
    if (got_q.size() != 9) begin errors++; $display("FAIL example_count got %0d exp 9", got_q.size()); end
    else for (int k = 0; k < 9; k++) begin
      checks++;
      if (got_q[k] !== ref_b[k]) begin errors++; $display("FAIL example_byte%0d got %h exp %h", k, got_q[k], ref_b[k]); end
    end
    checks++;
    if (addr_q.size() != 4) begin errors++; $display("FAIL example_addr_count got %0d exp 4", addr_q.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (addr_q[k] !== ADDR_W'(k)) begin errors++; $display("FAIL example_addr%0d got %0d exp %0d", k, addr_q[k], k); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL example_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_clamp();
    bit ok;
    fill_mem();
    mode = 0;
    build_exp(7);
    do_transfer(7, 5000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL clamp_timeout got no done exp done"); end
    checks++;
    if (got_q.size() != 33) begin errors++; $display("FAIL clamp_count got %0d exp 33", got_q.size()); end
    else for (int k = 0; k < 33; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL clamp_byte%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++;
    if (addr_q.size() != 16) begin errors++; $display("FAIL clamp_addr_count got %0d exp 16", addr_q.size()); end
    else if (addr_q[15] !== 4'd15) begin errors++; $display("FAIL clamp_last_addr got %0d exp 15", addr_q[15]); end
    checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL clamp_done got %0d/%0d exp 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_zero_no_header();
    int hi;
    @(posedge clk); #1;
    send_req0 = 1'b1;
    matrix_size0 = 4'd0;
    @(posedge clk); #1;
    send_req0 = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done0); end
    hi = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (tx_start0) hi++;
      if (c == 0) begin
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b exp 0", done0); end
      end
    end
    checks++; if (hi != 0 || err0 !== 1'b0) begin errors++; $display("FAIL zero_no_start got %0d/%b exp 0/0", hi, err0); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_obs();
    mode = 1;
    @(posedge clk); #1;
    send_req = 1'b1;
    matrix_size = 4'd1;
    @(posedge clk); #1;
    send_req = 1'b0;
    for (int c = 0; c < TMO + 200 && err_cnt == 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL timeout_err got %0d exp 1", err_cnt); end
    checks++; if (start_hi != TMO) begin errors++; $display("FAIL timeout_start_cycles got %0d exp %0d", start_hi, TMO); end
    checks++; if (done_cnt != 0 || sending !== 1'b0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got done=%0d sending=%b start=%b exp 0/0/0", done_cnt, sending, tx_start);
    end
    mode = 0;
    fill_mem();
    build_exp(1);
    do_transfer(1, 2000, ok);
    checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL timeout_recover got done=%0d exp 1", done_cnt); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_recover_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    else for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL timeout_recover_byte%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_ignore_req();
    fill_mem();
    mode = 0;
    build_exp(2);
    clear_obs();
    @(posedge clk); #1;
    send_req = 1'b1;
    matrix_size = 4'd2;
    @(posedge clk); #1;
    send_req = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++; if (sending !== 1'b1) begin errors++; $display("FAIL ignore_sending got %b exp 1", sending); end
    send_req = 1'b1;
    matrix_size = 4'd3;
    @(posedge clk); #1;
    send_req = 1'b0;
    for (int c = 0; c < 3000 && done_cnt == 0 && err_cnt == 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL ignore_done got %0d/%0d exp 1/0", done_cnt, err_cnt); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ignore_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    else for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL ignore_byte%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    fill_mem();
    mode = 2;
    clear_obs();
    @(posedge clk); #1;
    send_req = 1'b1;
    matrix_size = 4'd4;
    @(posedge clk); #1;
    send_req = 1'b0;
    for (int c = 0; c < 3000 && !(tx_start && got_q.size() >= 3); c++) begin
      @(posedge clk); #1;
    end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL midrst_reach got start=%b exp 1", tx_start); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b0 || sending !== 1'b0) begin errors++; $display("FAIL midrst_outputs got start=%b sending=%b exp 0/0", tx_start, sending); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_pulses got done=%b err=%b exp 0/0", done, err); end
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (done_cnt != 0 || err_cnt != 0 || tx_start !== 1'b0) begin
      errors++; $display("FAIL midrst_quiet got done=%0d err=%0d start=%b exp 0/0/0", done_cnt, err_cnt, tx_start);
    end
    mode = 0;
    build_exp(2);
    do_transfer(2, 3000, ok);
    checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL midrst_restart_done got %0d exp 1", done_cnt); end
    checks++;
    if (addr_q.size() == 0 || addr_q[0] !== '0) begin errors++; $display("FAIL midrst_restart_addr got size=%0d exp first addr 0", addr_q.size()); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    else for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL midrst_byte%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int ms;
    viol_cnt = 0;
    for (int it = 0; it < 4; it++) begin
      fill_mem();
      mode = (it == 0 || $urandom_range(0, 1) == 1) ? 2 : 0;
      ms = $urandom_range(0, 15);
      build_exp(ms);
      do_transfer(ms, 20000, ok);
      checks++; if (!ok || done_cnt != 1 || err_cnt != 0) begin
        errors++; $display("FAIL rand%0d_done ms=%0d got done=%0d err=%0d exp 1/0", it, ms, done_cnt, err_cnt);
      end
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size(), exp_q.size()); end
      else for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_byte%0d got %h exp %h", it, k, got_q[k], exp_q[k]); end
      end
      checks++;
      if (addr_q.size() != exp_addr.size()) begin errors++; $display("FAIL rand%0d_addr_count got %0d exp %0d", it, addr_q.size(), exp_addr.size()); end
      else for (int k = 0; k < exp_addr.size(); k++) begin
        checks++;
        if (addr_q[k] !== exp_addr[k]) begin errors++; $display("FAIL rand%0d_addr%0d got %0d exp %0d", it, k, addr_q[k], exp_addr[k]); end
      end
    end
    checks++; if (viol_cnt != 0) begin errors++; $display("FAIL tx_data_stability got %0d changes exp 0", viol_cnt); end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    send_req = 1'b0; matrix_size = '0;
    send_req0 = 1'b0; matrix_size0 = '0; tx_busy0 = 1'b0; res_data0 = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_spec_example();
    test_clamp();
    test_zero_no_header();
    test_timeout();
    test_ignore_req();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
